// File: rtl/zbt_arbiter.sv
// zbt_arbiter: shares the single-port pipelined ZBT between buffered NTSC writes and VGA reads.
// Define ZBT_ARB_STATS_EN to enable the saturating dropped-write counter on drop_cnt.
module zbt_arbiter #(
  parameter int AW       = 19,
  parameter int DW       = 36,
  parameter int FIFO_AW  = 2,
  parameter int READ_LAT = 2,
  parameter int MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ntsc_we,
  input  logic [AW-1:0] ntsc_addr,
  input  logic [DW-1:0] ntsc_data,
  input  logic          vram_re,
  input  logic [AW-1:0] vram_raddr,
  output logic          vram_ready,
  output logic          vram_rvalid,
  output logic [DW-1:0] vram_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          fifo_full,
  output logic [15:0]   drop_cnt
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int WCW   = $clog2(MAX_WAIT + 1);
  localparam int EW    = AW + DW;

  // Handshake: a read is accepted on any edge where vram_re and vram_ready are both high;
  // the requester holds vram_raddr until then. vram_ready depends only on force_wr_q.

  logic [EW-1:0]       fifo_mem_q [DEPTH];
  logic [FIFO_AW:0]    wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]    rd_ptr_q, rd_ptr_d;
  logic [WCW-1:0]      wait_cnt_q, wait_cnt_d;
  logic                force_wr_q, force_wr_d;
  logic [READ_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic [AW-1:0]       mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
  logic                vram_rvalid_q, vram_rvalid_d;
  logic [DW-1:0]       vram_rdata_q, vram_rdata_d;

  logic          fifo_empty;
  logic          fifo_full_w;
  logic          do_forced;
  logic          do_read;
  logic          do_write;
  logic          do_push;
  logic [EW-1:0] head;

  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_w = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                       (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign head        = fifo_mem_q[rd_ptr_q[FIFO_AW-1:0]];

  assign vram_ready  = ~force_wr_q;
  assign do_forced   = force_wr_q & ~fifo_empty;
  assign do_read     = ~do_forced & vram_re & vram_ready;
  assign do_write    = do_forced | (~do_read & ~fifo_empty);
  // A full FIFO still accepts a push on an edge that also pops.
  assign do_push     = ntsc_we & (~fifo_full_w | do_write);

  always_comb begin
    wr_ptr_d      = wr_ptr_q + {{FIFO_AW{1'b0}}, do_push};
    rd_ptr_d      = rd_ptr_q + {{FIFO_AW{1'b0}}, do_write};

    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_we_d      = 1'b0;
    if (do_write) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = head[EW-1:DW];
      mem_wdata_d = head[DW-1:0];
    end else if (do_read) begin
      mem_addr_d  = vram_raddr;
    end

    wait_cnt_d = wait_cnt_q;
    force_wr_d = force_wr_q;
    if (do_write || fifo_empty) begin
      wait_cnt_d = '0;
    end else begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end
    if (do_forced) begin
      force_wr_d = 1'b0;
    end else if (!fifo_empty && !do_write && wait_cnt_q == WCW'(MAX_WAIT - 1)) begin
      force_wr_d = 1'b1;
    end

    // Accept marker walks READ_LAT stages; the last stage captures mem_rdata.
    rd_pipe_d[0] = do_read;
    for (int i = 1; i < READ_LAT; i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end
    vram_rvalid_d = rd_pipe_q[READ_LAT-1];
    vram_rdata_d  = rd_pipe_q[READ_LAT-1] ? mem_rdata : vram_rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      wait_cnt_q    <= '0;
      force_wr_q    <= 1'b0;
      rd_pipe_q     <= '0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      vram_rvalid_q <= 1'b0;
      vram_rdata_q  <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      wait_cnt_q    <= wait_cnt_d;
      force_wr_q    <= force_wr_d;
      rd_pipe_q     <= rd_pipe_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      vram_rvalid_q <= vram_rvalid_d;
      vram_rdata_q  <= vram_rdata_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {ntsc_addr, ntsc_data};
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign vram_rvalid = vram_rvalid_q;
  assign vram_rdata  = vram_rdata_q;
  assign fifo_full   = fifo_full_w;

`ifdef ZBT_ARB_STATS_EN
  logic        do_drop;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  assign do_drop = ntsc_we & fifo_full_w & ~do_write;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (do_drop && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_zbt_arbiter.sv
// tb_zbt_arbiter: randomized traffic against a queue-based reference model of the ZBT arbiter.
// Expected writes/reads carry the cycle they must appear in; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_zbt_arbiter;
  localparam int AW       = 19;
  localparam int DW       = 36;
  localparam int FIFO_AW  = 2;
  localparam int READ_LAT = 2;
  localparam int MAX_WAIT = 3;
  localparam int DEPTH    = 1 << FIFO_AW;
  localparam int EW       = AW + DW;
  localparam int CW       = 32;

  logic          clk;
  logic          reset;
  logic          ntsc_we;
  logic [AW-1:0] ntsc_addr;
  logic [DW-1:0] ntsc_data;
  logic          vram_re;
  logic [AW-1:0] vram_raddr;
  logic          vram_ready;
  logic          vram_rvalid;
  logic [DW-1:0] vram_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          fifo_full;
  logic [15:0]   drop_cnt;

  zbt_arbiter #(
    .AW(AW), .DW(DW), .FIFO_AW(FIFO_AW), .READ_LAT(READ_LAT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .ntsc_we(ntsc_we), .ntsc_addr(ntsc_addr), .ntsc_data(ntsc_data),
    .vram_re(vram_re), .vram_raddr(vram_raddr), .vram_ready(vram_ready),
    .vram_rvalid(vram_rvalid), .vram_rdata(vram_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fifo_full(fifo_full), .drop_cnt(drop_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input bit ok, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Read data the memory returns for an address; 0x40 is pinned to a known pattern.
  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    if (a == 19'h00040) return 36'h5A5A5A5A5;
    return {a[16:0], ~a};
  endfunction

  // ZBT pipeline model: address registered at edge 0, data on the bus before edge READ_LAT.
  logic [AW-1:0] mem_a_lat = '0;
  always @(negedge clk) begin
    mem_rdata = data_of(mem_a_lat);
    mem_a_lat = mem_addr;
  end

  // ---------------- reference model ----------------
  logic [EW-1:0]    m_fifo[$];
  logic [CW+EW-1:0] exp_wr_q[$];
  logic [CW+DW-1:0] exp_rd_q[$];
  int               m_denied = 0;
  bit               m_force  = 1'b0;
  int               m_drops  = 0;
  bit               m_acc    = 1'b0;
  int               cyc      = 0;

  always @(posedge clk) begin : model
    int            occ;
    bit            wrote;
    logic [EW-1:0] ent;
    cyc++;
    m_acc = 1'b0;
    if (reset) begin
      m_fifo.delete();
      exp_wr_q.delete();
      exp_rd_q.delete();
      m_denied = 0;
      m_force  = 1'b0;
      m_drops  = 0;
    end else begin
      occ   = m_fifo.size();
      wrote = 1'b0;
      ent   = '0;
      if (m_force && occ > 0) begin
        ent = m_fifo.pop_front();
        wrote = 1'b1;
      end else if (vram_re && !m_force) begin
        m_acc = 1'b1;
        exp_rd_q.push_back({32'(cyc + READ_LAT), data_of(vram_raddr)});
      end else if (occ > 0) begin
        ent = m_fifo.pop_front();
        wrote = 1'b1;
      end
      if (wrote) exp_wr_q.push_back({32'(cyc), ent});
      if (ntsc_we) begin
        if (occ < DEPTH || wrote) m_fifo.push_back({ntsc_addr, ntsc_data});
        else m_drops++;
      end
      if (wrote) begin
        m_denied = 0;
        m_force  = 1'b0;
      end else if (occ > 0) begin
        m_denied++;
        if (m_denied >= MAX_WAIT) m_force = 1'b1;
      end else begin
        m_denied = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [CW+EW-1:0] we_e;
    logic [CW+DW-1:0] re_e;
    if (reset) begin
      check("rst_mem_we",      mem_we == 1'b0,      mem_we,      0);
      check("rst_mem_addr",    mem_addr == '0,      mem_addr,    0);
      check("rst_mem_wdata",   mem_wdata == '0,     mem_wdata,   0);
      check("rst_vram_rvalid", vram_rvalid == 1'b0, vram_rvalid, 0);
      check("rst_vram_rdata",  vram_rdata == '0,    vram_rdata,  0);
      check("rst_vram_ready",  vram_ready == 1'b1,  vram_ready,  1);
      check("rst_fifo_full",   fifo_full == 1'b0,   fifo_full,   0);
      check("rst_drop_cnt",    drop_cnt == 16'd0,   drop_cnt,    0);
    end else begin
      check("vram_ready", vram_ready == !m_force, vram_ready, !m_force);
      check("fifo_full", fifo_full == (m_fifo.size() == DEPTH), fifo_full, m_fifo.size() == DEPTH);

      if (mem_we) begin
        if (exp_wr_q.size() == 0) begin
          check("unexpected_write", 1'b0, {mem_addr, mem_wdata}, 0);
        end else begin
          we_e = exp_wr_q.pop_front();
          check("write_cycle", we_e[CW+EW-1 -: CW] == 32'(cyc), cyc, we_e[CW+EW-1 -: CW]);
          check("write_addr_data", {mem_addr, mem_wdata} == we_e[EW-1:0], {mem_addr, mem_wdata}, we_e[EW-1:0]);
        end
      end else if (exp_wr_q.size() > 0) begin
        we_e = exp_wr_q[0];
        if (we_e[CW+EW-1 -: CW] <= 32'(cyc)) begin
          void'(exp_wr_q.pop_front());
          check("missing_write", 1'b0, 0, we_e[EW-1:0]);
        end
      end

      if (vram_rvalid) begin
        if (exp_rd_q.size() == 0) begin
          check("unexpected_rvalid", 1'b0, vram_rdata, 0);
        end else begin
          re_e = exp_rd_q.pop_front();
          check("read_cycle", re_e[CW+DW-1 -: CW] == 32'(cyc), cyc, re_e[CW+DW-1 -: CW]);
          check("read_data", vram_rdata == re_e[DW-1:0], vram_rdata, re_e[DW-1:0]);
        end
      end else if (exp_rd_q.size() > 0) begin
        re_e = exp_rd_q[0];
        if (re_e[CW+DW-1 -: CW] <= 32'(cyc)) begin
          void'(exp_rd_q.pop_front());
          check("missing_rvalid", 1'b0, 0, re_e[DW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One cycle of stimulus; a raised read stays held until the model reports it accepted.
  task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit want_rd, input logic [AW-1:0] ra);
    ntsc_we   = we;
    ntsc_addr = wa;
    ntsc_data = wd;
    if (!vram_re && want_rd) begin
      vram_re    = 1'b1;
      vram_raddr = ra;
    end
    step();
    if (vram_re && m_acc) vram_re = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic rd_only(input int n);
    repeat (n) drive(1'b0, '0, '0, 1'b1, AW'($urandom));
  endtask

  task automatic check_drops(input string name);
    int exp;
`ifdef ZBT_ARB_STATS_EN
    exp = (m_drops > 65535) ? 65535 : m_drops;
`else
    exp = 0;
`endif
    check(name, drop_cnt == 16'(exp), drop_cnt, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset      = 1'b1;
    ntsc_we    = 1'b0;
    ntsc_addr  = '0;
    ntsc_data  = '0;
    vram_re    = 1'b0;
    vram_raddr = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    idle(10);

    // single buffered write, no reads
    drive(1'b1, 19'h00123, 36'hABCDE0001, 1'b0, '0);
    idle(6);

    // single read of the pinned address
    drive(1'b0, '0, '0, 1'b1, 19'h00040);
    idle(6);

    // continuous reads with one write that must be forced through
    rd_only(4);
    drive(1'b1, AW'($urandom), DW'({$urandom, $urandom}), 1'b1, AW'($urandom));
    rd_only(8);
    idle(8);

    // burst of six writes against a held read stream overflows the FIFO
    rd_only(2);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, AW'(32'h100 + i), DW'({$urandom, $urandom}), 1'b1, AW'($urandom));
    end
    rd_only(4);
    idle(12);
    check_drops("drop_cnt_burst");

    // reset one cycle after a read accept with three writes queued
    rd_only(1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, AW'(32'h200 + i), DW'({$urandom, $urandom}), 1'b1, AW'($urandom));
    end
    rd_only(1);
    reset   = 1'b1;
    ntsc_we = 1'b0;
    vram_re = 1'b0;
    step();
    reset = 1'b0;
    idle(10);
    check("fifo_full_after_reset", fifo_full == 1'b0, fifo_full, 0);
    check_drops("drop_cnt_after_reset");

    // randomized mixed traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 99) < 45, AW'($urandom), DW'({$urandom, $urandom}),
            $urandom_range(0, 99) < 70, AW'($urandom));
    end
    idle(20);
    check_drops("drop_cnt_final");
    check("wr_queue_drained", exp_wr_q.size() == 0, exp_wr_q.size(), 0);
    check("rd_queue_drained", exp_rd_q.size() == 0, exp_rd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
